// File: rtl/prefix_add_seq_pkg.sv
// Shared types for the sequential prefix-adder arbiter.
// Word width, FSM state encoding and requester id.
package prefix_add_seq_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef logic id_t;

endpackage

// File: rtl/GPTPrefix16_L9.sv
// 16-bit Kogge-Stone prefix adder, no carry-in.
// Four log stages of generate/propagate merging.
module GPTPrefix16_L9 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g [5];
  logic [15:0] p [5];

  // Prefix tree over bitwise generate/propagate
  always_comb begin
    g[0] = a_i & b_i;
    p[0] = a_i ^ b_i;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << l)) begin
          g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
          p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
        end else begin
          g[l+1][i] = g[l][i];
          p[l+1][i] = p[l][i];
        end
      end
    end
    sum_o  = p[0] ^ {g[4][14:0], 1'b0};
    cout_o = g[4][15];
  end

endmodule

// File: rtl/prefix_rr_arb2.sv
// Two-way round-robin grant; ptr picks winner on a tie.
// Purely combinational, pointer is owned by the caller.
module prefix_rr_arb2
  import prefix_add_seq_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  id_t        ptr_i,
  output logic [1:0] grant_o,
  output id_t        gnt_id_o
);

  // One-hot grant: sole requester wins, ptr breaks ties
  always_comb begin
    grant_o[0] = valid0_i & (~valid1_i | (ptr_i == 1'b0));
    grant_o[1] = valid1_i & (~valid0_i | (ptr_i == 1'b1));
    gnt_id_o   = grant_o[1];
  end

endmodule

// File: rtl/prefix_add_seq_arb.sv
// Two requesters share one 16-bit prefix adder; wide adds
// run LSW-first, with an extra +1 pass for pending carries.
module prefix_add_seq_arb
  import prefix_add_seq_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [WORD_W*NWORDS-1:0] req0_a,
  input  logic [WORD_W*NWORDS-1:0] req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [WORD_W*NWORDS-1:0] req1_a,
  input  logic [WORD_W*NWORDS-1:0] req1_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [WORD_W*NWORDS-1:0] rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy
);

  localparam int WIDTH = WORD_W * NWORDS;
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  state_e            state_q, state_d;
  id_t               rr_q, id_q, gnt_id;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic [KW-1:0]     k_q;
  logic              carry_q, c1_q, cout_q, valid_q;
  logic [WORD_W-1:0] s_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic [WORD_W-1:0] a_k, b_k, add_a, add_b, add_s;
  logic              add_c, last, need_fix, carry_nx;

  prefix_rr_arb2 u_arb (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .ptr_i    (rr_q),
    .grant_o  (gnt),
    .gnt_id_o (gnt_id)
  );

  GPTPrefix16_L9 u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .sum_o  (add_s),
    .cout_o (add_c)
  );

  assign gnt_any  = |gnt;
  assign a_k      = a_q[int'(k_q)*WORD_W +: WORD_W];
  assign b_k      = b_q[int'(k_q)*WORD_W +: WORD_W];
  assign last     = (k_q == K_LAST);
  assign need_fix = carry_q & (k_q != '0);
  assign carry_nx = (state_q == FIX) ? (c1_q | add_c) : add_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: ADD detours via FIX when a carry is pending
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_any) state_d = ADD;
      ADD: begin
        if (need_fix)  state_d = FIX;
        else if (last) state_d = RESP;
      end
      FIX:  state_d = last ? RESP : ADD;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready only in IDLE, adder quiet outside ADD/FIX
  always_comb begin
    add_a      = '0;
    add_b      = '0;
    req0_ready = rst_n & (state_q == IDLE) & gnt[0];
    req1_ready = rst_n & (state_q == IDLE) & gnt[1];
    unique case (state_q)
      ADD: begin
        add_a = a_k;
        add_b = b_k;
      end
      FIX: begin
        add_a = s_q;
        add_b = 16'h0001;
      end
      default: ;
    endcase
  end

  // Datapath: capture operands, assemble words, publish result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      k_q     <= '0;
      carry_q <= 1'b0;
      c1_q    <= 1'b0;
      s_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (gnt_any) begin
          a_q     <= gnt[1] ? req1_a : req0_a;
          b_q     <= gnt[1] ? req1_b : req0_b;
          id_q    <= gnt_id;
          rr_q    <= ~gnt_id;
          k_q     <= '0;
          carry_q <= 1'b0;
        end
        ADD, FIX: begin
          if (state_q == ADD && need_fix) begin
            s_q  <= add_s;
            c1_q <= add_c;
          end else begin
            sum_q[int'(k_q)*WORD_W +: WORD_W] <= add_s;
            carry_q <= carry_nx;
            if (last) begin
              cout_q  <= carry_nx;
              valid_q <= 1'b1;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        RESP: if (rsp_ready) valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_prefix_add_seq_arb.sv
// Bench for prefix_add_seq_arb: vector table, scoreboard,
// and directed sequences for arbitration, stall and reset.
module tb_prefix_add_seq_arb;

  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_ready = 1'b1;
  logic         rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  prefix_add_seq_arb #(.NWORDS(NW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    bit          id;
    logic [63:0] sum;
    bit          cout;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    bit          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] es;
    bit          ec;
    int          el;
  } vec_t;

  exp_t sbq[$];
  int   glog[$];
  bit   seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  // Reference: wide sum plus count of words entering with carry
  function automatic exp_t model(input bit id, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t        e;
    logic [64:0] t;
    logic [16:0] w;
    bit          c;
    int          f;
    c = 1'b0;
    f = 0;
    t = {1'b0, a} + {1'b0, b};
    for (int k = 0; k < NW; k++) begin
      if (k > 0 && c) f++;
      w = {1'b0, a[k*16 +: 16]} + {1'b0, b[k*16 +: 16]} + {16'd0, c};
      c = w[16];
    end
    e.id   = id;
    e.sum  = t[63:0];
    e.cout = t[64];
    e.lat  = NW + f;
    e.acc  = 0;
    return e;
  endfunction

  // Scoreboard: push on request handshake, pop on response handshake
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      seen = 1'b0;
    end else begin
      if (req0_valid && req0_ready) begin
        e = model(1'b0, req0_a, req0_b);
        e.acc = cyc + 1;
        sbq.push_back(e);
        glog.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        e = model(1'b1, req1_a, req1_b);
        e.acc = cyc + 1;
        sbq.push_back(e);
        glog.push_back(1);
      end
      if (rsp_valid && !seen) begin
        seen = 1'b1;
        if (sbq.size() == 0) fail_now("sb_unexpected_rsp");
        else chk("sb_latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
      end
      if (!rsp_valid) seen = 1'b0;
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          fail_now("sb_empty_pop");
        end else begin
          e = sbq.pop_front();
          chk("sb_sum", rsp_sum, e.sum);
          chk("sb_cout", 64'(rsp_cout), 64'(e.cout));
          chk("sb_id", 64'(rsp_id), 64'(e.id));
        end
      end
    end
  end

  task automatic issue(input bit id, input logic [63:0] a,
                       input logic [63:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    if (id) begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("issue_timeout");
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) return;
    end
    fail_now("rsp_timeout");
    lat = -1;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!busy && !rsp_valid && sbq.size() == 0) return;
    end
    fail_now("drain_timeout");
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        vt[5];
    int          lat;
    logic [63:0] ones;
    ones = '1;

    vt[0] = '{1'b0, 64'd1, 64'd2, 64'd3, 1'b0, 4};
    vt[1] = '{1'b1, ones, 64'd1, 64'd0, 1'b1, 7};
    vt[2] = '{1'b0, 64'h0000_FFFF_0000_FFFF, 64'd1,
              64'h0000_FFFF_0001_0000, 1'b0, 5};
    vt[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'd0, 1'b1, 4};
    vt[4] = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              64'h2222_2222_2222_2211, 1'b0, 7};

    // Both requesters valid while reset is held
    req0_a = 64'd5; req0_b = 64'd6; req0_valid = 1'b1;
    req1_a = 64'd7; req1_b = 64'd8; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", rsp_sum, 64'd0);
    chk("rst_cout", 64'(rsp_cout), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention: four back-to-back grants must alternate
    begin
      bit got4;
      got4 = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(posedge clk);
        #1;
        if (glog.size() >= 4) begin
          got4 = 1'b1;
          break;
        end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (!got4) fail_now("rr_grant_timeout");
    end
    drain();
    if (glog.size() == 4) begin
      chk("rr_grant0", 64'(glog[0]), 64'd0);
      chk("rr_grant1", 64'(glog[1]), 64'd1);
      chk("rr_grant2", 64'(glog[2]), 64'd0);
      chk("rr_grant3", 64'(glog[3]), 64'd1);
    end else begin
      chk("rr_grant_count", 64'(glog.size()), 64'd4);
    end
    glog.delete();

    // Single-requester vectors
    for (int i = 0; i < 5; i++) begin
      issue(vt[i].id, vt[i].a, vt[i].b);
      wait_rsp(lat);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].el));
      chk($sformatf("vec%0d_sum", i), rsp_sum, vt[i].es);
      chk($sformatf("vec%0d_cout", i), 64'(rsp_cout), 64'(vt[i].ec));
      chk($sformatf("vec%0d_id", i), 64'(rsp_id), 64'(vt[i].id));
      drain();
    end

    // Response back-pressure with a competing request
    rsp_ready = 1'b0;
    issue(1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555);
    wait_rsp(lat);
    req1_a = 64'd3;
    req1_b = 64'd4;
    req1_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_sum", rsp_sum, ones);
      chk("stall_cout", 64'(rsp_cout), 64'd0);
      chk("stall_id", 64'(rsp_id), 64'd0);
      chk("stall_ready0", 64'(req0_ready), 64'd0);
      chk("stall_ready1", 64'(req1_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_rel_valid", 64'(rsp_valid), 64'd0);
    chk("stall_rel_busy", 64'(busy), 64'd0);
    chk("stall_rel_ready1", 64'(req1_ready), 64'd1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    drain();

    // Reset while the adder is in a +1 fix-up pass
    issue(1'b1, ones, 64'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    req0_a = 64'd9;
    req0_b = 64'd9;
    req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_sum", rsp_sum, 64'd0);
    chk("mid_rst_cout", 64'(rsp_cout), 64'd0);
    chk("mid_rst_id", 64'(rsp_id), 64'd0);
    chk("mid_rst_ready0", 64'(req0_ready), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    issue(1'b0, 64'h0000_0000_0000_FFFF, 64'd1);
    wait_rsp(lat);
    chk("post_rst_lat", 64'(lat), 64'd5);
    chk("post_rst_sum", rsp_sum, 64'h0000_0000_0001_0000);
    chk("post_rst_cout", 64'(rsp_cout), 64'd0);
    chk("post_rst_id", 64'(rsp_id), 64'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
